// File: rtl/csa_pkg.sv
// ============================================================================
// Package : csa_pkg
// Shared types and sizing helpers for the chunk-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

  // Controller state encoding.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of chunk cycles needed to cover the full operand width.
  function automatic int csa_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; never narrower than one bit so NCH=1 still has a counter.
  function automatic int csa_cnt_w(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_chunk.sv
// ============================================================================
// Module  : full_adder_chunk
// Combinational CHUNK-bit ripple of full-adder cells. Also exposes the carry
// into the chunk MSB so the caller can form signed overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // w_c[i] is the carry into bit i; w_c[CHUNK] is the carry out of the chunk.
  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  // One full-adder cell per bit, rippling the carry upward.
  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign co       = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/chunk_serial_adder.sv
// ============================================================================
// Module  : chunk_serial_adder
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock with
// a start/busy/done handshake. Subtraction is A + ~B + ~Cin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_serial_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCH = csa_nch(WIDTH, CHUNK);
  localparam int CW  = csa_cnt_w(NCH);

  localparam logic [CW-1:0]    c_last = CW'(NCH - 1);
  localparam logic [CHUNK-1:0] c_ones = '1;
  localparam logic [WIDTH-1:0] c_mask = WIDTH'(c_ones);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // B already inverted for subtract
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic [31:0]      w_lsb;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_res_next;

  // Select the active chunk of each operand by shifting it down to bit 0.
  assign w_lsb     = 32'(r_cnt) * 32'(CHUNK);
  assign w_a_chunk = CHUNK'(r_a >> w_lsb);
  assign w_b_chunk = CHUNK'(r_b >> w_lsb);

  full_adder_chunk #(
    .CHUNK (CHUNK)
  ) u_fa (
    .a        (w_a_chunk),
    .b        (w_b_chunk),
    .ci       (r_carry),
    .s        (w_s),
    .co       (w_co),
    .c_msb_in (w_cmsb)
  );

  // Result register with the current chunk merged in; used both for the
  // running result and for the final Sum so the last chunk is not lost.
  always_comb begin
    w_res_next = (r_res & ~(c_mask << w_lsb)) | (WIDTH'(w_s) << w_lsb);
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? ~Cin : Cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            // Only the top chunk's carries determine Cout and Ovf.
            r_sum   <= w_res_next;
            r_cout  <= w_co;
            r_ovf   <= w_cmsb ^ w_co;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunk_serial_adder.sv
// ============================================================================
// Module  : tb_chunk_serial_adder
// Self-checking bench: directed vectors on the 16/4 configuration plus a
// parameter sweep against a behavioural reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0, Sub = 1'b0;
  logic        busy, done, Cout, Ovf;
  logic [15:0] Sum;

  // Sweep instances share one set of inputs.
  logic        sw_start = 1'b0;
  logic [15:0] sA = '0, sB = '0;
  logic        sCin = 1'b0, sSub = 1'b0;
  logic [3:0]  sw_done, sw_busy, sw_cout, sw_ovf;
  logic [15:0] sum_c1, sum_c2, sum_c16;
  logic [7:0]  sum_w8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .A(sA), .B(sB), .Cin(sCin), .Sub(sSub),
    .busy(sw_busy[0]), .done(sw_done[0]), .Sum(sum_c1), .Cout(sw_cout[0]), .Ovf(sw_ovf[0]));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .A(sA), .B(sB), .Cin(sCin), .Sub(sSub),
    .busy(sw_busy[1]), .done(sw_done[1]), .Sum(sum_c2), .Cout(sw_cout[1]), .Ovf(sw_ovf[1]));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .A(sA), .B(sB), .Cin(sCin), .Sub(sSub),
    .busy(sw_busy[2]), .done(sw_done[2]), .Sum(sum_c16), .Cout(sw_cout[2]), .Ovf(sw_ovf[2]));

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .A(sA[7:0]), .B(sB[7:0]), .Cin(sCin), .Sub(sSub),
    .busy(sw_busy[3]), .done(sw_done[3]), .Sum(sum_w8), .Cout(sw_cout[3]), .Ovf(sw_ovf[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for a w-bit add/sub, overflow from operand signs.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [31:0] mask, aa, bb, full;
    logic        ci, sa, sb, ss;
    mask = (32'd1 << w) - 32'd1;
    aa   = {16'd0, a} & mask;
    bb   = (sub ? {16'd0, ~b} : {16'd0, b}) & mask;
    ci   = sub ? ~cin : cin;
    full = aa + bb + {31'd0, ci};
    sa   = aa[w-1];
    sb   = bb[w-1];
    ss   = full[w-1];
    return {(sa == sb) && (ss != sa), full[w], full[15:0] & mask[15:0]};
  endfunction

  // Issue one operation on the main DUT and wait (bounded) for done.
  task automatic run_main(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output logic [15:0] s, output logic co,
                          output logic ov, output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    lat = -1; bcnt = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = j - 1;
        break;
      end
    end
    s = Sum; co = Cout; ov = Ovf;
  endtask

  logic [15:0] r_s;
  logic        r_co, r_ov;
  int          lat, bcnt, dcnt;

  // Directed vectors: {A, B, Cin, Sub, Sum, Cout, Ovf}.
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  vec_t vecs[6] = '{
    '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0}
  };

  int          exp_nch[4] = '{16, 8, 1, 1};
  int          exp_w[4]   = '{16, 16, 16, 8};
  int          slat[4];
  logic [15:0] ss[4];
  logic        sco[4], sov[4];
  logic [17:0] rv;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {16'd0, Sum},  32'd0);
    check("rst_cout", {31'd0, Cout}, 32'd0);
    check("rst_ovf",  {31'd0, Ovf},  32'd0);
    rst_n = 1'b1;

    // Directed add/sub vectors
    foreach (vecs[i]) begin
      run_main(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r_s, r_co, r_ov, lat, bcnt);
      check($sformatf("v%0d_sum", i),  {16'd0, r_s},  {16'd0, vecs[i].s});
      check($sformatf("v%0d_cout", i), {31'd0, r_co}, {31'd0, vecs[i].co});
      check($sformatf("v%0d_ovf", i),  {31'd0, r_ov}, {31'd0, vecs[i].ov});
      check($sformatf("v%0d_lat", i),  lat,  32'd4);
      check($sformatf("v%0d_busy", i), bcnt, 32'd4);
    end

    // start during RUN is ignored
    @(negedge clk);
    A = 16'h1234; B = 16'h0FCD; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (j == 2) begin A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b1; start = 1'b1; end
      if (j == 3) start = 1'b0;
      if (done) begin lat = j - 1; break; end
    end
    check("ign_sum", {16'd0, Sum}, 32'h2201);
    check("ign_lat", lat, 32'd4);
    @(negedge clk);
    check("ign_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: start asserted in the done cycle
    @(negedge clk);
    A = 16'h0005; B = 16'h0007; Cin = 1'b0; Sub = 1'b1; start = 1'b1;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (done) begin lat = j - 1; break; end
    end
    check("b2b_first_lat", lat, 32'd4);
    A = 16'h7FFF; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) check("b2b_hold", {16'd0, Sum}, 32'hFFFE);
      if (done) begin lat = k; break; end
    end
    check("b2b_gap", lat, 32'd5);
    check("b2b_sum", {16'd0, Sum}, 32'h8000);
    check("b2b_ovf", {31'd0, Ovf}, 32'd1);

    // Asynchronous reset mid-operation
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_sum",  {16'd0, Sum},  32'd0);
    check("arst_ovf",  {31'd0, Ovf},  32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("arst_nodone", dcnt, 32'd0);
    run_main(16'h1111, 16'h2222, 1'b1, 1'b0, r_s, r_co, r_ov, lat, bcnt);
    check("arst_next_sum", {16'd0, r_s}, 32'h3334);
    check("arst_next_lat", lat, 32'd4);

    // Parameter sweep against the reference model
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      if (v == 0) begin
        sA = 16'hFFFF; sB = 16'h0001; sCin = 1'b0; sSub = 1'b0;
      end else begin
        sA = 16'($urandom); sB = 16'($urandom);
        sCin = 1'($urandom_range(0, 1)); sSub = 1'($urandom_range(0, 1));
      end
      sw_start = 1'b1;
      for (int i = 0; i < 4; i++) slat[i] = -1;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (j == 1) sw_start = 1'b0;
        if (sw_done[0] && slat[0] < 0) begin slat[0] = j - 1; ss[0] = sum_c1;  sco[0] = sw_cout[0]; sov[0] = sw_ovf[0]; end
        if (sw_done[1] && slat[1] < 0) begin slat[1] = j - 1; ss[1] = sum_c2;  sco[1] = sw_cout[1]; sov[1] = sw_ovf[1]; end
        if (sw_done[2] && slat[2] < 0) begin slat[2] = j - 1; ss[2] = sum_c16; sco[2] = sw_cout[2]; sov[2] = sw_ovf[2]; end
        if (sw_done[3] && slat[3] < 0) begin slat[3] = j - 1; ss[3] = {8'd0, sum_w8}; sco[3] = sw_cout[3]; sov[3] = sw_ovf[3]; end
        if (slat[0] >= 0 && slat[1] >= 0 && slat[2] >= 0 && slat[3] >= 0) break;
      end
      for (int i = 0; i < 4; i++) begin
        rv = ref_op(exp_w[i], sA, sB, sCin, sSub);
        check($sformatf("sw%0d_v%0d_lat", i, v), slat[i], exp_nch[i]);
        if (slat[i] >= 0) begin
          check($sformatf("sw%0d_v%0d_sum", i, v),  {16'd0, ss[i]},  {16'd0, rv[15:0]});
          check($sformatf("sw%0d_v%0d_cout", i, v), {31'd0, sco[i]}, {31'd0, rv[16]});
          check($sformatf("sw%0d_v%0d_ovf", i, v),  {31'd0, sov[i]}, {31'd0, rv[17]});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
